// File: rtl/oh_buffer_arb_pkg.sv
// Shared types and constants for the oh_buffer_arb round-robin buffer arbiter.
// Lock state encoding is used only when OH_BUFFER_ARB_LOCK_EN is defined.
package oh_buffer_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  localparam int CW    = 2;
  localparam int DEPTH = 2;

endpackage

// File: rtl/oh_buffer_arb_rr_pick.sv
// oh_rr_pick: combinational round-robin picker.
// Rotates req so last_ptr+1 sits at bit 0, takes the lowest set bit, and unrotates.
module oh_rr_pick #(
  parameter int N  = 4,
  parameter int LW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last_ptr,
  output logic [N-1:0]  grant
);

  logic [LW:0]    shamt;
  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   rot;
  logic [N-1:0]   pri;
  logic [2*N-1:0] pri_dbl;

  always_comb begin
    shamt   = {1'b0, last_ptr} + 1'b1;
    req_dbl = {req, req} >> shamt;
    rot     = req_dbl[N-1:0];
    pri     = rot & (~rot + 1'b1);
    // the upper half of the doubled word holds the unrotated index
    pri_dbl = {pri, pri} << shamt;
    grant   = pri_dbl[2*N-1:N];
  end

endmodule

// File: rtl/oh_buffer_arb.sv
// oh_buffer_arb: N-way round-robin arbiter feeding a shared 2-entry output buffer.
// Define OH_BUFFER_ARB_LOCK_EN to add in_last and a per-packet grant lock.
module oh_buffer_arb
  import oh_buffer_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  in_valid,
  input  logic [N*DW-1:0] in_data,
`ifdef OH_BUFFER_ARB_LOCK_EN
  input  logic [N-1:0]  in_last,
`endif
  output logic [N-1:0]  in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [N-1:0]  out_grant,
  output logic          busy
);

  localparam int LW = $clog2(N);

  logic [CW-1:0] count_q, count_d;
  logic [LW-1:0] last_ptr_q, last_ptr_d;
  logic          head_q, head_d;
  logic          tail_q, tail_d;
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [N-1:0]  gnt_q [DEPTH];
  logic [N-1:0]  gnt_d [DEPTH];

  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic          space;
  logic          push;
  logic          pop;
  logic [LW-1:0] win_idx;
  logic [DW-1:0] win_data;

`ifdef OH_BUFFER_ARB_LOCK_EN
  lock_state_e lock_q, lock_d;
  logic [N-1:0] lock_mask;

  always_comb begin
    lock_mask = (lock_q == LOCKED) ? (N'(1) << last_ptr_q) : '1;
    req       = in_valid & lock_mask;
  end

  always_comb begin
    lock_d = lock_q;
    unique case (lock_q)
      IDLE:   if (push && !in_last[win_idx]) lock_d = LOCKED;
      LOCKED: if (push && in_last[win_idx])  lock_d = IDLE;
      default: lock_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) lock_q <= IDLE;
    else       lock_q <= lock_d;
  end
`else
  always_comb req = in_valid;
`endif

  oh_rr_pick #(
    .N  (N),
    .LW (LW)
  ) u_pick (
    .req      (req),
    .last_ptr (last_ptr_q),
    .grant    (grant)
  );

  always_comb begin
    win_idx  = '0;
    win_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) win_idx = LW'(i);
      win_data = win_data | (in_data[i*DW +: DW] & {DW{grant[i]}});
    end
  end

  always_comb begin
    space     = count_q < CW'(DEPTH);
    in_ready  = reset ? '0 : (grant & {N{space}});
    out_valid = !reset && (count_q != '0);
    busy      = !reset && (count_q != '0);
    push      = |(in_valid & in_ready);
    pop       = out_valid & out_ready;
    out_data  = out_valid ? data_q[head_q] : '0;
    out_grant = out_valid ? gnt_q[head_q] : '0;
  end

  always_comb begin
    count_d    = count_q + CW'(push) - CW'(pop);
    last_ptr_d = push ? win_idx : last_ptr_q;
    head_d     = head_q ^ pop;
    tail_d     = tail_q ^ push;
    data_d     = data_q;
    gnt_d      = gnt_q;
    if (push) begin
      data_d[tail_q] = win_data;
      gnt_d[tail_q]  = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      last_ptr_q <= LW'(N-1);
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        gnt_q[i]  <= '0;
      end
    end else begin
      count_q    <= count_d;
      last_ptr_q <= last_ptr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      data_q     <= data_d;
      gnt_q      <= gnt_d;
    end
  end

endmodule

// File: tb/tb_oh_buffer_arb.sv
// Self-checking bench for oh_buffer_arb: arbitration/queue model plus scenario tasks.
// Lock scenario runs only when OH_BUFFER_ARB_LOCK_EN is defined.
module tb_oh_buffer_arb;

  localparam int N  = 4;
  localparam int DW = 32;

  logic          clk;
  logic          reset;
  logic [N-1:0]  in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]  in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [N-1:0]  out_grant;
  logic          busy;
`ifdef OH_BUFFER_ARB_LOCK_EN
  logic [N-1:0]  in_last;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int seq    = 0;

  logic [N+DW-1:0] sbq[$];
  int mcount;
  int mlast;
  int mlock;

  oh_buffer_arb #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef OH_BUFFER_ARB_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_grant (out_grant),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] rr(input logic [N-1:0] r, input int lp);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (lp + k) % N;
      if (r[idx]) return N'(1) << idx;
    end
    return '0;
  endfunction

  // Reference model and scoreboard, evaluated where inputs are stable
  always @(negedge clk) begin
    logic [N-1:0] rq;
    logic [N-1:0] exp_ready;
    logic [N+DW-1:0] exp_w;
    int mpush, mpop, idx;
    if (reset) begin
      n_chk++;
      if (in_ready !== '0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: in_ready=%b out_valid=%b required 0000/0",
                 in_ready, out_valid);
      end
      sbq.delete();
      mcount = 0;
      mlast  = N - 1;
      mlock  = 0;
    end else begin
      rq = in_valid;
      if (mlock != 0) rq = in_valid & (N'(1) << mlast);
      exp_ready = (mcount < 2) ? rr(rq, mlast) : '0;
      n_chk++;
      if (in_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL arb_ready: in_ready=%b required %b", in_ready, exp_ready);
      end
      n_chk++;
      if (out_valid !== (mcount != 0)) begin
        n_fail++;
        $display("FAIL model_out_valid: got %b required %b", out_valid, mcount != 0);
      end
      mpop  = (mcount != 0 && out_ready) ? 1 : 0;
      mpush = (|(in_valid & exp_ready)) ? 1 : 0;
      if (mpop != 0) begin
        n_chk++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow: output popped with empty scoreboard");
        end else begin
          exp_w = sbq.pop_front();
          if ({out_grant, out_data} !== exp_w) begin
            n_fail++;
            $display("FAIL sb_word: got grant=%b data=%h required grant=%b data=%h",
                     out_grant, out_data, exp_w[N+DW-1:DW], exp_w[DW-1:0]);
          end
        end
      end
      if (mpush != 0) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (exp_ready[i]) idx = i;
        sbq.push_back({exp_ready, in_data[idx*DW +: DW]});
        mlast = idx;
`ifdef OH_BUFFER_ARB_LOCK_EN
        if (mlock == 0 && !in_last[idx]) mlock = 1;
        else if (mlock != 0 && in_last[idx]) mlock = 0;
`endif
      end
      mcount = mcount + mpush - mpop;
    end
  end

  task automatic refresh_data();
    for (int i = 0; i < N; i++)
      in_data[i*DW +: DW] = {i[7:0], seq[23:0]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    seq++;
    refresh_data();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = '0;
    out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++;
      if (in_ready !== 4'b0000 || out_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: in_ready=%b out_valid=%b busy=%b required 0000/0/0",
                 in_ready, out_valid, busy);
      end
      step();
    end
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_first_grant: in_ready=%b required 0001", in_ready);
    end
    step();
    in_valid = '0;
    step();
    step();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] e;
    do_reset();
    in_valid  = 4'hF;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      e = N'(1) << (i % N);
      n_chk++;
      if (in_ready !== e) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: in_ready=%b required %b", i, in_ready, e);
      end
      if (i > 0) begin
        n_chk++;
        if (out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL rr_throughput[%0d]: out_valid=%b required 1", i, out_valid);
        end
      end
      step();
    end
    in_valid = '0;
    step();
    step();
  endtask

  task automatic test_stall();
    logic [DW-1:0] w1, w2;
    do_reset();
    in_valid  = 4'b0110;
    out_ready = 1'b0;
    @(negedge clk);
    w1 = in_data[1*DW +: DW];
    step();
    @(negedge clk);
    w2 = in_data[2*DW +: DW];
    step();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_chk++;
      if (in_ready !== 4'b0000 || busy !== 1'b1 || out_data !== w1 ||
          out_grant !== 4'b0010) begin
        n_fail++;
        $display("FAIL stall_hold: in_ready=%b busy=%b data=%h grant=%b required 0000/1/%h/0010",
                 in_ready, busy, out_data, out_grant, w1);
      end
      step();
    end
    in_valid  = '0;
    out_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (out_data !== w1) begin
      n_fail++;
      $display("FAIL stall_drain0: data=%h required %h", out_data, w1);
    end
    step();
    @(negedge clk);
    n_chk++;
    if (out_data !== w2 || out_grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL stall_drain1: data=%h grant=%b required %h/0100",
               out_data, out_grant, w2);
    end
    step();
    step();
  endtask

  task automatic test_push_pop();
    do_reset();
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    step();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b1 || out_valid !== 1'b1 || in_ready !== 4'b0001) begin
        n_fail++;
        $display("FAIL push_pop[%0d]: busy=%b out_valid=%b in_ready=%b required 1/1/0001",
                 c, busy, out_valid, in_ready);
      end
      step();
    end
    in_valid = '0;
    step();
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL push_pop_empty: busy=%b required 0", busy);
    end
    step();
  endtask

  task automatic test_single_toggle();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2 == 0) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      n_chk++;
      if (i % 2 == 1) begin
        if (out_valid !== 1'b1 || out_grant !== 4'b1000) begin
          n_fail++;
          $display("FAIL toggle_grant[%0d]: out_valid=%b out_grant=%b required 1/1000",
                   i, out_valid, out_grant);
        end
      end else if (i > 0 && (out_valid !== 1'b0 || out_grant !== 4'b0000)) begin
        n_fail++;
        $display("FAIL toggle_idle[%0d]: out_valid=%b out_grant=%b required 0/0000",
                 i, out_valid, out_grant);
      end
      step();
    end
    in_valid = 4'hF;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL toggle_next: in_ready=%b required 0001", in_ready);
    end
    step();
    in_valid = '0;
    step();
    step();
  endtask

`ifdef OH_BUFFER_ARB_LOCK_EN
  task automatic test_lock();
    logic [N-1:0] exp_r [4];
    logic [N-1:0] vld [4];
    logic [N-1:0] lst [4];
    exp_r = '{4'b0010, 4'b0010, 4'b0010, 4'b0001};
    vld   = '{4'b0010, 4'b0011, 4'b0011, 4'b0011};
    lst   = '{4'b0000, 4'b0000, 4'b0010, 4'b0001};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = vld[i];
      in_last  = lst[i];
      @(negedge clk);
      n_chk++;
      if (in_ready !== exp_r[i]) begin
        n_fail++;
        $display("FAIL lock_grant[%0d]: in_ready=%b required %b", i, in_ready, exp_r[i]);
      end
      step();
    end
    in_valid = '0;
    in_last  = '0;
    step();
    step();
  endtask
`endif

  task automatic test_flush();
    do_reset();
    in_valid  = 4'b0011;
    out_ready = 1'b0;
    step();
    step();
    in_valid = '0;
    reset    = 1'b1;
    step();
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_chk++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL flush[%0d]: out_valid=%b busy=%b required 0/0", c, out_valid, busy);
      end
      step();
    end
  endtask

  task automatic test_drain();
    int budget;
    in_valid  = '0;
    out_ready = 1'b1;
    budget    = 20;
    while (sbq.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d words outstanding required 0", sbq.size());
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = '0;
    out_ready = 1'b0;
    in_data   = '0;
`ifdef OH_BUFFER_ARB_LOCK_EN
    in_last   = '1;
`endif
    refresh_data();
    test_reset();
    test_round_robin();
    test_stall();
    test_push_pop();
    test_single_toggle();
`ifdef OH_BUFFER_ARB_LOCK_EN
    test_lock();
`endif
    test_flush();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
